// File: rtl/triangle_setup.sv
// Triangle setup: groups vertices into triangles, computes doubled area and a
// screen-clipped bounding box, culls, and queues survivors in a FWFT FIFO.
module triangle_setup #(
  parameter int FIFO_DEPTH = 4,
  parameter bit CULL_BACK  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic [38:0]  rast_pt,
  input  logic         rast_pt_valid,
  input  logic [11:0]  img_w,
  input  logic [11:0]  img_h,
  output logic         tri_valid,
  input  logic         tri_ready,
  output logic [116:0] tri_verts,
  output logic [47:0]  tri_bbox,
  output logic [28:0]  tri_area,
  output logic         tri_culled,
  output logic         overflow
);

  localparam int DATA_W = 13;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TRI_W  = 117 + 48 + 29;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  function automatic logic signed [DATA_W-1:0] coord(input logic [38:0] v, input int axis);
    return $signed(v[axis*DATA_W +: DATA_W]);
  endfunction

  function automatic logic signed [DATA_W-1:0] min3(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b,
                                                    input logic signed [DATA_W-1:0] c);
    logic signed [DATA_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [DATA_W-1:0] max3(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b,
                                                    input logic signed [DATA_W-1:0] c);
    logic signed [DATA_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [11:0] clip_lo(input logic signed [DATA_W-1:0] v);
    return (v < 0) ? 12'd0 : v[11:0];
  endfunction

  function automatic logic [11:0] clip_hi(input logic signed [DATA_W-1:0] v,
                                          input logic signed [DATA_W:0]   lim);
    return (14'(v) > lim) ? lim[11:0] : v[11:0];
  endfunction

  // Vertex grouping
  logic [1:0]  vcnt;
  logic [38:0] v0_hold, v1_hold;
  logic        launch;

  assign launch = rast_pt_valid && !frame_start && (vcnt == 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      vcnt <= 2'd0;
    else if (frame_start)
      vcnt <= rast_pt_valid ? 2'd1 : 2'd0;
    else if (rast_pt_valid)
      vcnt <= (vcnt == 2'd2) ? 2'd0 : vcnt + 2'd1;
  end

  // S1: vertex triple
  logic [116:0] verts_p0;
  logic         vld_p0;

  always_ff @(posedge clk) begin
    if (rast_pt_valid && (frame_start || vcnt == 2'd0)) v0_hold <= rast_pt;
    if (rast_pt_valid && !frame_start && vcnt == 2'd1)  v1_hold <= rast_pt;
    if (launch) verts_p0 <= {rast_pt, v1_hold, v0_hold};
  end

  logic signed [DATA_W-1:0] x0, y0, x1, y1, x2, y2;
  logic signed [DATA_W:0]   d1x, d1y, d2x, d2y;

  always_comb begin
    x0  = coord(verts_p0[38:0], 0);
    y0  = coord(verts_p0[38:0], 1);
    x1  = coord(verts_p0[77:39], 0);
    y1  = coord(verts_p0[77:39], 1);
    x2  = coord(verts_p0[116:78], 0);
    y2  = coord(verts_p0[116:78], 1);
    d1x = 14'(x1) - 14'(x0);
    d1y = 14'(y1) - 14'(y0);
    d2x = 14'(x2) - 14'(x0);
    d2y = 14'(y2) - 14'(y0);
  end

  // S2: cross-product terms and raw extents
  logic [116:0]             verts_p1;
  logic signed [27:0]       prod1_p1, prod2_p1;
  logic signed [DATA_W-1:0] minx_p1, maxx_p1, miny_p1, maxy_p1;
  logic                     vld_p1;

  always_ff @(posedge clk) begin
    verts_p1 <= verts_p0;
    prod1_p1 <= 28'(d1x) * 28'(d2y);
    prod2_p1 <= 28'(d2x) * 28'(d1y);
    minx_p1  <= min3(x0, x1, x2);
    maxx_p1  <= max3(x0, x1, x2);
    miny_p1  <= min3(y0, y1, y2);
    maxy_p1  <= max3(y0, y1, y2);
  end

  // S3: area, clipping and cull decision
  logic [116:0]             verts_p2;
  logic signed [28:0]       area_p2;
  logic signed [DATA_W-1:0] minx_p2, maxx_p2, miny_p2, maxy_p2;
  logic                     vld_p2;

  always_ff @(posedge clk) begin
    verts_p2 <= verts_p1;
    area_p2  <= 29'(prod1_p1) - 29'(prod2_p1);
    minx_p2  <= minx_p1;
    maxx_p2  <= maxx_p1;
    miny_p2  <= miny_p1;
    maxy_p2  <= maxy_p1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= launch;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  logic signed [DATA_W:0] wm1, hm1;
  logic                   cull;
  logic [47:0]            bbox_c;

  always_comb begin
    wm1    = $signed({2'b00, img_w}) - 14'sd1;
    hm1    = $signed({2'b00, img_h}) - 14'sd1;
    bbox_c = {clip_hi(maxy_p2, hm1), clip_hi(maxx_p2, wm1), clip_lo(miny_p2), clip_lo(minx_p2)};
    cull   = (area_p2 == 29'sd0) || (CULL_BACK && area_p2 < 0) ||
             (maxx_p2 < 0) || (14'(minx_p2) > wm1) ||
             (maxy_p2 < 0) || (14'(miny_p2) > hm1) ||
             (img_w == 12'd0) || (img_h == 12'd0);
  end

  // Output FIFO (first-word-fall-through)
  logic [TRI_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, wr_en, full;

  assign full  = (count == FULL_CNT);
  assign push  = vld_p2 && !cull;
  assign pop   = tri_valid && tri_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {verts_p2, bbox_c, area_p2};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      tri_culled <= 1'b0;
    end else begin
      tri_culled <= vld_p2 && cull;
      if (push && !wr_en) overflow <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [TRI_W-1:0] head;

  always_comb begin
    tri_valid = (count != '0);
    head      = tri_valid ? mem[rd_ptr] : '0;
    tri_verts = head[TRI_W-1 -: 117];
    tri_bbox  = head[76:29];
    tri_area  = head[28:0];
  end

endmodule

// File: tb/tb_triangle_setup.sv
// Scoreboard bench for triangle_setup: one instance with back-face culling and
// backpressure control, one without culling and always ready.
module tb_triangle_setup;

  logic         clk = 1'b0;
  logic         rst, frame_start, rast_pt_valid;
  logic [38:0]  rast_pt;
  logic [11:0]  img_w, img_h;
  logic         tri_ready_a, tri_ready_b;
  logic         tri_valid_a, tri_valid_b, tri_culled_a, tri_culled_b, overflow_a, overflow_b;
  logic [116:0] tri_verts_a, tri_verts_b;
  logic [47:0]  tri_bbox_a, tri_bbox_b;
  logic [28:0]  tri_area_a, tri_area_b;

  always #5 clk = ~clk;

  triangle_setup #(.FIFO_DEPTH(4), .CULL_BACK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .frame_start(frame_start), .rast_pt(rast_pt),
    .rast_pt_valid(rast_pt_valid), .img_w(img_w), .img_h(img_h),
    .tri_valid(tri_valid_a), .tri_ready(tri_ready_a), .tri_verts(tri_verts_a),
    .tri_bbox(tri_bbox_a), .tri_area(tri_area_a), .tri_culled(tri_culled_a),
    .overflow(overflow_a));

  triangle_setup #(.FIFO_DEPTH(4), .CULL_BACK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .frame_start(frame_start), .rast_pt(rast_pt),
    .rast_pt_valid(rast_pt_valid), .img_w(img_w), .img_h(img_h),
    .tri_valid(tri_valid_b), .tri_ready(tri_ready_b), .tri_verts(tri_verts_b),
    .tri_bbox(tri_bbox_b), .tri_area(tri_area_b), .tri_culled(tri_culled_b),
    .overflow(overflow_b));

  typedef struct packed {
    logic [116:0] verts;
    logic [47:0]  bbox;
    logic [28:0]  area;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   culled_a = 0;
  int   culled_b = 0;

  function automatic logic [38:0] pt(input int x, input int y, input int z);
    return {13'(z), 13'(y), 13'(x)};
  endfunction

  function automatic logic [47:0] bb(input int xmin, input int ymin, input int xmax, input int ymax);
    return {12'(ymax), 12'(xmax), 12'(ymin), 12'(xmin)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_verts(input string name, input logic [116:0] act, input logic [116:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [38:0] p, input logic fs);
    @(posedge clk); #1;
    rast_pt       = p;
    rast_pt_valid = 1'b1;
    frame_start   = fs;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rast_pt_valid = 1'b0;
      frame_start   = 1'b0;
    end
  endtask

  task automatic expect_tri(input logic [38:0] a, input logic [38:0] b, input logic [38:0] c,
                            input logic [47:0] box, input int area, input bit to_a, input bit to_b);
    exp_t e;
    e.verts = {c, b, a};
    e.bbox  = box;
    e.area  = 29'(area);
    if (to_a) qa.push_back(e);
    if (to_b) qb.push_back(e);
  endtask

  task automatic send_tri(input logic [38:0] a, input logic [38:0] b, input logic [38:0] c);
    drive(a, 1'b0);
    drive(b, 1'b0);
    drive(c, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (tri_valid_a && tri_ready_a) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected actual=%0h required=none", tri_area_a);
        end else begin
          e = qa.pop_front();
          check_verts("a_verts", tri_verts_a, e.verts);
          check("a_bbox", 128'(tri_bbox_a), 128'(e.bbox));
          check("a_area", 128'(tri_area_a), 128'(e.area));
        end
      end
      if (tri_valid_b && tri_ready_b) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual=%0h required=none", tri_area_b);
        end else begin
          e = qb.pop_front();
          check_verts("b_verts", tri_verts_b, e.verts);
          check("b_bbox", 128'(tri_bbox_b), 128'(e.bbox));
          check("b_area", 128'(tri_area_b), 128'(e.area));
        end
      end
      if (tri_culled_a) culled_a++;
      if (tri_culled_b) culled_b++;
    end
  end

  initial begin
    rst = 1'b0; frame_start = 1'b0; rast_pt_valid = 1'b0; rast_pt = '0;
    img_w = 12'd640; img_h = 12'd480;
    tri_ready_a = 1'b1; tri_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(tri_valid_a), 128'd0);
    check("rst_culled", 128'(tri_culled_a), 128'd0);
    check("rst_overflow", 128'(overflow_a), 128'd0);
    check_verts("rst_verts", tri_verts_a, 117'd0);
    check("rst_bbox", 128'(tri_bbox_a), 128'd0);
    check("rst_area", 128'(tri_area_a), 128'd0);
    rst = 1'b1;

    // Front-facing, with latency check
    expect_tri(pt(0,0,5), pt(10,0,6), pt(0,10,7), bb(0,0,10,10), 100, 1'b1, 1'b1);
    send_tri(pt(0,0,5), pt(10,0,6), pt(0,10,7));
    idle(1);
    repeat (3) @(negedge clk);
    check("lat_not_yet", 128'(tri_valid_a), 128'd0);
    @(negedge clk);
    check("lat_valid", 128'(tri_valid_a), 128'd1);
    idle(6);

    // Back-facing: culled on a, emitted on b
    expect_tri(pt(0,0,5), pt(0,10,7), pt(10,0,6), bb(0,0,10,10), -100, 1'b0, 1'b1);
    send_tri(pt(0,0,5), pt(0,10,7), pt(10,0,6));
    idle(6);

    // Clipped
    expect_tri(pt(-20,-5,1), pt(700,30,2), pt(5,500,3), bb(0,0,639,479), 362725, 1'b1, 1'b1);
    send_tri(pt(-20,-5,1), pt(700,30,2), pt(5,500,3));
    idle(6);

    // Off-screen and degenerate
    send_tri(pt(700,10,0), pt(800,10,0), pt(700,50,0));
    send_tri(pt(0,0,0), pt(5,5,0), pt(10,10,0));
    idle(8);
    check("cull_overflow_a", 128'(overflow_a), 128'd0);
    check("cull_overflow_b", 128'(overflow_b), 128'd0);

    // Backpressure: five back-to-back into a four-deep FIFO
    @(posedge clk); #1;
    tri_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_tri(pt(i,0,i+1), pt(10+i,0,i+2), pt(i,10,i+3), bb(i,0,10+i,10), 100, i < 4, 1'b1);
      send_tri(pt(i,0,i+1), pt(10+i,0,i+2), pt(i,10,i+3));
    end
    idle(8);
    check("bp_overflow_a", 128'(overflow_a), 128'd1);
    check("bp_overflow_b", 128'(overflow_b), 128'd0);
    check("bp_held_valid", 128'(tri_valid_a), 128'd1);
    @(posedge clk); #1;
    tri_ready_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_valid", 128'(tri_valid_a), 128'd1);
    end
    @(negedge clk);
    check("drain_empty", 128'(tri_valid_a), 128'd0);
    idle(2);

    // Reset mid-triangle
    drive(pt(300,300,1), 1'b0);
    drive(pt(400,300,2), 1'b0);
    @(posedge clk); #1;
    rast_pt_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("post_rst_overflow", 128'(overflow_a), 128'd0);
    expect_tri(pt(0,0,5), pt(10,0,6), pt(0,10,7), bb(0,0,10,10), 100, 1'b1, 1'b1);
    send_tri(pt(0,0,5), pt(10,0,6), pt(0,10,7));
    idle(8);

    // frame_start with a vertex in the same cycle
    drive(pt(100,100,1), 1'b0);
    drive(pt(200,200,2), 1'b0);
    expect_tri(pt(0,0,5), pt(10,0,6), pt(0,10,7), bb(0,0,10,10), 100, 1'b1, 1'b1);
    drive(pt(0,0,5), 1'b1);
    drive(pt(10,0,6), 1'b0);
    drive(pt(0,10,7), 1'b0);
    idle(10);

    check("qa_empty", 128'(qa.size()), 128'd0);
    check("qb_empty", 128'(qb.size()), 128'd0);
    check("culled_a", 128'(culled_a), 128'd3);
    check("culled_b", 128'(culled_b), 128'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
